comparator_bias_ctrl: RTL
=========================

# comparator_bias_ctrl

Digital sequencer for the multi-channel comparator bias generator: powers up the bias core, holds a settle interval, then ramps each channel's trim code one LSB at a time toward a programmed target before declaring the bias ready. It is the parametrised successor to the fixed two-output comparator bias block. It sits between the user-project Wishbone/logic-analyzer control registers and the analog bias core, which consumes `bias_en` and the per-channel trim codes. Ramping avoids comparator glitches from large bias steps.

## Interface
- `NCH`, 2: number of bias channels (e.g. VBN, VBP); ≥1
- `CODE_W`, 6: trim code width per channel; ≥2
- `SETTLE_CYC`, 16: settle interval in clocks after power-up and after each ramp; ≥1
- `RAMP_DIV`, 4: clocks per one-LSB ramp step; ≥1

- `VDD`/`VSS`  inout  1  power pins, present only under `USE_POWER_PINS`
- `wb_clk_i`  in  1  clock
- `wb_rst_i`  in  1  reset, synchronous, active-high
- `en`  in  1  bias enable request, level
- `tgt_load`  in  1  single-cycle strobe; latch `tgt_code`
- `tgt_code`  in  NCH*CODE_W  target codes; channel i at bits [i*CODE_W +: CODE_W]
- `bias_en`  out  1  power enable to analog bias core
- `bias_code`  out  NCH*CODE_W  current trim codes, same packing as `tgt_code`
- `ready`  out  1  codes equal targets and settled
- `busy`  out  1  in STARTUP, RAMP or SETTLE
- `state_o`  out  3  encoded state for debug: OFF=0, STARTUP=1, RAMP=2, SETTLE=3, READY=4

## Operation
- All outputs and internal registers are registered. Reset values: state OFF, `bias_en`=0, `bias_code`=0, targets=0, `ready`=0, `busy`=0, `state_o`=0. Counters reset to 0.
- Target registers: latched from `tgt_code` on any cycle with `tgt_load`=1, in every state. Reset has priority over `tgt_load`.
- OFF: `bias_en`=0, codes held at 0. When `en`=1, go to STARTUP with `bias_en`=1 and settle counter=0.
- STARTUP: codes stay 0. The settle counter increments each cycle. At count SETTLE_CYC-1, go to RAMP with prescaler=0.
- RAMP: evaluated each cycle, in this priority order:
  - If every channel code equals its target, go to SETTLE with counter=0.
  - Otherwise, if prescaler==RAMP_DIV-1, every unequal channel steps ±1 toward its target and the prescaler resets to 0.
  - Otherwise, the prescaler increments.
  - Channels step independently and in parallel. A channel already at target does not move. No overflow or underflow is possible.
- SETTLE: the counter increments. At count SETTLE_CYC-1, go to READY.
- SETTLE with `tgt_load`: return to RAMP with prescaler=0. This happens even if the new targets equal the current codes; RAMP then exits after 1 cycle.
- READY: `ready`=1. A `tgt_load` moves the block to RAMP with prescaler=0, and `ready` drops on that same edge.
- `en`=0 in any state other than OFF: go to OFF on the next edge. That edge clears `bias_en`, codes, `ready` and counters. Targets are retained.
- `busy` = state ∈ {STARTUP, RAMP, SETTLE}. `ready` = state==READY.

## Timing
- Measured from the edge that samples `en`=1 in OFF: `bias_en` is high immediately after that edge.
- Let D = the maximum over channels of |target − 0|. `ready` rises after SETTLE_CYC + D*RAMP_DIV + 1 + SETTLE_CYC edges.
- A D=0 startup gives SETTLE_CYC + 1 + SETTLE_CYC.
- Retarget from READY with step distance D: `ready` is low from the load edge. It returns after D*RAMP_DIV + 1 + SETTLE_CYC further edges.
- `tgt_load` during RAMP: new targets take effect for the next step decision. The prescaler is not reset.
- `en` and `tgt_load` on the same edge in OFF: targets latch and STARTUP begins. Both take effect.
- Reset mid-ramp: all outputs return to reset values on that edge, regardless of `en`.

## Test plan
- Power-up. Parameters NCH=2, CODE_W=4, SETTLE_CYC=4, RAMP_DIV=2; targets {3,1} loaded in OFF; `en`=1.
  - Response: `bias_en` rises 1 edge later; `bias_code` is 0 for 4 cycles.
  - ch1 reaches 1 and ch0 reaches 3 at 2-cycle steps.
  - `ready` rises exactly 15 edges after `en` is sampled; `busy` is high throughout until then.
- Retarget down. From READY at {3,1}, load {0,3}.
  - Response: `ready` falls on the load edge; ch0 steps 3→2→1→0 while ch1 steps 1→2→3.
  - `ready` returns after 3*2+1+4=11 edges.
- Load during SETTLE. Load new targets {5,5} in cycle 2 of SETTLE.
  - Response: state goes back to RAMP; the settle counter restarts after ramp completion; `ready` does not assert early.
- Disable mid-ramp. `en`=0 while the codes are {2,1}.
  - Response: next edge gives `bias_en`=0, codes 0, state OFF, targets kept.
  - Re-enabling ramps to the old targets.
- Reset priority. Assert `wb_rst_i` together with `tgt_load` and `en` while in READY.
  - Response: all outputs 0, targets 0; no latch occurs.
- Edge parameters. SETTLE_CYC=1, RAMP_DIV=1, CODE_W=2, target 3.
  - Response: the code steps every cycle 0→3; `ready` comes 1+3+1+1=6 edges after `en`.

Source files
------------

// File: rtl/comparator_bias_ctrl.sv
// comparator_bias_ctrl
//
// Power-up and trim sequencer for the multi-channel comparator bias core.
// On enable it powers the core, waits a settle interval, then walks every
// channel's trim code one LSB per RAMP_DIV clocks toward its programmed
// target. After a second settle interval it reports ready. Small steps keep
// the comparators from glitching on large bias jumps.
//
// Ports
//   VDD/VSS    power pins (only with USE_POWER_PINS)
//   wb_clk_i   clock
//   wb_rst_i   synchronous active-high reset
//   en         level enable request; low returns the block to OFF
//   tgt_load   one-cycle strobe that latches tgt_code (accepted in any state)
//   tgt_code   packed targets, channel i at [i*CODE_W +: CODE_W]
//   bias_en    power enable to the analog bias core
//   bias_code  current trim codes, same packing as tgt_code
//   ready      codes at target and settled
//   busy       sequencing (STARTUP, RAMP or SETTLE)
//   state_o    debug state: OFF=0 STARTUP=1 RAMP=2 SETTLE=3 READY=4
module comparator_bias_ctrl #(
  parameter int NCH        = 2,
  parameter int CODE_W     = 6,
  parameter int SETTLE_CYC = 16,
  parameter int RAMP_DIV   = 4
) (
`ifdef USE_POWER_PINS
  inout  wire                   VDD,
  inout  wire                   VSS,
`endif
  input  logic                  wb_clk_i,
  input  logic                  wb_rst_i,
  input  logic                  en,
  input  logic                  tgt_load,
  input  logic [NCH*CODE_W-1:0] tgt_code,
  output logic                  bias_en,
  output logic [NCH*CODE_W-1:0] bias_code,
  output logic                  ready,
  output logic                  busy,
  output logic [2:0]            state_o
);

  localparam int SW = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;
  localparam int PW = (RAMP_DIV > 1) ? $clog2(RAMP_DIV) : 1;
  localparam logic [SW-1:0] SETTLE_LAST = SW'(SETTLE_CYC - 1);
  localparam logic [PW-1:0] PRESC_LAST  = PW'(RAMP_DIV - 1);

  typedef enum logic [2:0] {
    ST_OFF     = 3'd0,
    ST_STARTUP = 3'd1,
    ST_RAMP    = 3'd2,
    ST_SETTLE  = 3'd3,
    ST_READY   = 3'd4
  } state_t;

  state_t                state_reg, state_next;
  logic [SW-1:0]         settle_cnt_reg, settle_cnt_next;
  logic [PW-1:0]         presc_reg, presc_next;
  logic [NCH*CODE_W-1:0] code_reg, code_next;
  logic [NCH*CODE_W-1:0] tgt_reg;
  logic                  bias_en_reg, bias_en_next;
  logic                  ready_reg, ready_next;
  logic                  busy_reg, busy_next;

  // Per-channel step toward target; a channel already at target holds.
  logic [NCH-1:0]        ch_at_tgt;
  logic [NCH*CODE_W-1:0] code_step;
  logic                  all_at_tgt;

  for (genvar gi = 0; gi < NCH; gi++) begin : g_ch
    logic [CODE_W-1:0] cur;
    logic [CODE_W-1:0] tgt;
    assign cur = code_reg[gi*CODE_W +: CODE_W];
    assign tgt = tgt_reg[gi*CODE_W +: CODE_W];
    assign ch_at_tgt[gi] = (cur == tgt);
    assign code_step[gi*CODE_W +: CODE_W] =
      (cur < tgt) ? cur + CODE_W'(1) :
      (cur > tgt) ? cur - CODE_W'(1) : cur;
  end

  assign all_at_tgt = &ch_at_tgt;

  always_comb begin
    state_next      = state_reg;
    settle_cnt_next = settle_cnt_reg;
    presc_next      = presc_reg;
    code_next       = code_reg;

    if (state_reg != ST_OFF && !en) begin
      // Dropping en from any active state powers down in one edge.
      state_next      = ST_OFF;
      settle_cnt_next = '0;
      presc_next      = '0;
      code_next       = '0;
    end else begin
      unique case (state_reg)
        ST_OFF: begin
          code_next = '0;
          if (en) begin
            state_next      = ST_STARTUP;
            settle_cnt_next = '0;
          end
        end
        ST_STARTUP: begin
          if (settle_cnt_reg == SETTLE_LAST) begin
            state_next = ST_RAMP;
            presc_next = '0;
          end else begin
            settle_cnt_next = settle_cnt_reg + SW'(1);
          end
        end
        ST_RAMP: begin
          // Equality is checked before stepping, so RAMP always spends one
          // extra cycle confirming the final code before settling.
          if (all_at_tgt) begin
            state_next      = ST_SETTLE;
            settle_cnt_next = '0;
          end else if (presc_reg == PRESC_LAST) begin
            code_next  = code_step;
            presc_next = '0;
          end else begin
            presc_next = presc_reg + PW'(1);
          end
        end
        ST_SETTLE: begin
          // A new target restarts the ramp even if it matches the codes.
          if (tgt_load) begin
            state_next = ST_RAMP;
            presc_next = '0;
          end else if (settle_cnt_reg == SETTLE_LAST) begin
            state_next = ST_READY;
          end else begin
            settle_cnt_next = settle_cnt_reg + SW'(1);
          end
        end
        ST_READY: begin
          if (tgt_load) begin
            state_next = ST_RAMP;
            presc_next = '0;
          end
        end
        default: begin
          state_next      = ST_OFF;
          settle_cnt_next = '0;
          presc_next      = '0;
          code_next       = '0;
        end
      endcase
    end
  end

  // Status outputs are registered from the next state so they change on
  // the same edge as the state itself.
  always_comb begin
    bias_en_next = (state_next != ST_OFF);
    busy_next    = (state_next == ST_STARTUP) || (state_next == ST_RAMP) ||
                   (state_next == ST_SETTLE);
    ready_next   = (state_next == ST_READY);
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state_reg      <= ST_OFF;
      settle_cnt_reg <= '0;
      presc_reg      <= '0;
      code_reg       <= '0;
      tgt_reg        <= '0;
      bias_en_reg    <= 1'b0;
      ready_reg      <= 1'b0;
      busy_reg       <= 1'b0;
    end else begin
      state_reg      <= state_next;
      settle_cnt_reg <= settle_cnt_next;
      presc_reg      <= presc_next;
      code_reg       <= code_next;
      bias_en_reg    <= bias_en_next;
      ready_reg      <= ready_next;
      busy_reg       <= busy_next;
      if (tgt_load) begin
        tgt_reg <= tgt_code;
      end
    end
  end

  assign bias_en   = bias_en_reg;
  assign bias_code = code_reg;
  assign ready     = ready_reg;
  assign busy      = busy_reg;
  assign state_o   = state_reg;

endmodule
